// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps an LSTMCell through one input sequence.
// Accepts x_t vectors, presents x_t / h window / c to the cell, captures the
// cell outputs after CELL_LAT cycles, folds h_t into the window and emits it.
module lstm_seq_ctrl #(
    parameter int unsigned SEQ_LEN  = 8,
    parameter int unsigned CELL_LAT = 6,
    parameter int unsigned STEP_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [63:0]       x_data,
    output logic [63:0]       cell_xt,
    output logic [63:0]       cell_ht1,
    output logic [7:0]        cell_ct1,
    input  logic [7:0]        cell_ht,
    input  logic [7:0]        cell_ct,
    output logic              h_valid,
    input  logic              h_ready,
    output logic [7:0]        h_data,
    output logic              h_last,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy
);

    localparam int unsigned       CntW     = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
    localparam logic [CntW-1:0]   CntLast  = CntW'(CELL_LAT - 1);
    localparam logic [STEP_W-1:0] StepLast = STEP_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StSettle,
        StEmit
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       xt_q, xt_d;
    logic [63:0]       hist_q, hist_d;
    logic [7:0]        c_q, c_d;
    logic [7:0]        h_data_q, h_data_d;
    logic              h_last_q, h_last_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // State and datapath registers; reset clears everything, losing any partial step.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            xt_q     <= '0;
            hist_q   <= '0;
            c_q      <= '0;
            h_data_q <= '0;
            h_last_q <= 1'b0;
            step_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            xt_q     <= xt_d;
            hist_q   <= hist_d;
            c_q      <= c_d;
            h_data_q <= h_data_d;
            h_last_q <= h_last_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and handshake decode; registers hold unless a state updates them.
    always_comb begin
        state_d  = state_q;
        xt_d     = xt_q;
        hist_d   = hist_q;
        c_d      = c_q;
        h_data_d = h_data_q;
        h_last_d = h_last_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        x_ready  = 1'b0;
        h_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hist_d  = '0;
                    c_d     = '0;
                    step_d  = '0;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    xt_d    = x_data;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Cell inputs have been stable CELL_LAT-1 cycles; outputs valid now.
                if (cnt_q == CntLast) begin
                    hist_d   = {hist_q[55:0], cell_ht};
                    c_d      = cell_ct;
                    h_data_d = cell_ht;
                    h_last_d = (step_q == StepLast);
                    state_d  = StEmit;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StEmit: begin
                h_valid = 1'b1;
                if (h_ready) begin
                    if (h_last_q) begin
                        step_d  = '0;
                        state_d = StIdle;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = StAccept;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered values straight to the outputs.
    always_comb begin
        cell_xt  = xt_q;
        cell_ht1 = hist_q;
        cell_ct1 = c_q;
        h_data   = h_data_q;
        h_last   = h_last_q;
        step_idx = step_q;
        busy     = (state_q != StIdle);
    end

endmodule
